// File: rtl/fake_mario_gpio_edge.sv
// fake_mario_gpio_edge: parametrised Avalon-MM GPIO port.
// Provides per-bit direction control, an input synchroniser, sticky edge
// capture with a maskable level interrupt, and a read-only config register.
// Optional feature macro: FAKE_MARIO_GPIO_SETCLR_EN. When it is defined,
// addresses 4/5 perform atomic set/clear of the output data register.
// When it is undefined, writes to 4/5 are ignored.
module fake_mario_gpio_edge #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  typedef enum logic [2:0] {
    ADDR_DATA   = 3'd0,
    ADDR_DIR    = 3'd1,
    ADDR_MASK   = 3'd2,
    ADDR_EDGE   = 3'd3,
    ADDR_OUTSET = 3'd4,
    ADDR_OUTCLR = 3'd5,
    ADDR_CONFIG = 3'd6,
    ADDR_RSVD   = 3'd7
  } reg_addr_e;

`ifdef FAKE_MARIO_GPIO_SETCLR_EN
  localparam logic SETCLR_PRESENT = 1'b1;
`else
  localparam logic SETCLR_PRESENT = 1'b0;
`endif

  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  reg_addr_e                     addr_sel;
  logic                          wr_en;
  logic [WIDTH-1:0]              wdata;
  logic                          unused_wdata;

  logic [WIDTH-1:0]              data_out;
  logic [WIDTH-1:0]              dir;
  logic [WIDTH-1:0]              mask;
  logic [WIDTH-1:0]              edgecap;
  logic [WIDTH-1:0]              edgecap_next;
  logic [WIDTH-1:0]              ec_clr;
  logic [WIDTH-1:0]              ec_set;

  logic [SYNC_STAGES*WIDTH-1:0]  sync_chain;
  logic [WIDTH-1:0]              in_sync;
  logic [WIDTH-1:0]              prev;
  logic [WIDTH-1:0]              edge_hit;

  logic [2:0]                    warm_cnt;
  logic                          warm_done;

  logic [31:0]                   rd_next;
  logic [31:0]                   cfg_word;

  assign addr_sel     = reg_addr_e'(address);
  assign wr_en        = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  // Bits of writedata above WIDTH are deliberately ignored.
  assign unused_wdata = ^writedata;

  assign in_sync   = sync_chain[SYNC_STAGES*WIDTH-1 -: WIDTH];
  assign warm_done = (warm_cnt == WARM_MAX);

  assign out_port  = data_out;
  assign out_en    = dir;
  assign irq       = |(edgecap & mask);

  // Input synchroniser chain (stage 0 in the low slice) plus one-clock delayed copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain <= '0;
      prev       <= '0;
    end else begin
      sync_chain <= {sync_chain[(SYNC_STAGES-1)*WIDTH-1:0], in_port};
      prev       <= in_sync;
    end
  end

  // Warm-up counter: saturates once the synchroniser and prev hold real pin data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 3'd1;
    end
  end

  // Edge detector selected by EDGE_TYPE.
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = in_sync & ~prev;
      1:       edge_hit = ~in_sync & prev;
      default: edge_hit = in_sync ^ prev;
    endcase
  end

  // Edge-capture next state: a new edge beats a same-cycle W1C on that bit.
  always_comb begin
    ec_clr = '0;
    if (wr_en && addr_sel == ADDR_EDGE) begin
      ec_clr = wdata;
    end
    ec_set       = warm_done ? edge_hit : '0;
    edgecap_next = (edgecap & ~ec_clr) | ec_set;
  end

  // Sticky edge-capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
    end else begin
      edgecap <= edgecap_next;
    end
  end

  // Writable control/data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= '0;
      mask     <= '0;
    end else if (wr_en) begin
      case (addr_sel)
        ADDR_DATA:   data_out <= wdata;
        ADDR_DIR:    dir      <= wdata;
        ADDR_MASK:   mask     <= wdata;
`ifdef FAKE_MARIO_GPIO_SETCLR_EN
        ADDR_OUTSET: data_out <= data_out | wdata;
        ADDR_OUTCLR: data_out <= data_out & ~wdata;
`endif
        default: ;
      endcase
    end
  end

  // Read-only configuration word.
  always_comb begin
    cfg_word       = '0;
    cfg_word[5:0]  = 6'(WIDTH);
    cfg_word[9:8]  = 2'(EDGE_TYPE);
    cfg_word[10]   = SETCLR_PRESENT;
  end

  // Read mux; decoded every cycle regardless of chipselect.
  always_comb begin
    rd_next = '0;
    case (addr_sel)
      ADDR_DATA:   rd_next[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
      ADDR_DIR:    rd_next[WIDTH-1:0] = dir;
      ADDR_MASK:   rd_next[WIDTH-1:0] = mask;
      ADDR_EDGE:   rd_next[WIDTH-1:0] = edgecap;
      ADDR_CONFIG: rd_next            = cfg_word;
      default:     rd_next            = '0;
    endcase
  end

  // Registered read data, one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule
